i2s_dac_serializer: RTL

- Output stage directly downstream of the effects chain. Takes the 32-bit left/right sample words produced by the last effect (e.g. tremolo DOUTL/DOUTR) and serializes them onto the codec's DACDAT line in I2S format.
- The codec is bus master; BCLK and LRCLK are inputs, oversampled in the single system clock domain (CLK, 50 MHz).
- Sits between the effects pipeline and the top-level codec pins.

---
 rtl/i2s_pkg.sv | 25 ++
 rtl/i2s_dac_serializer_if.sv | 47 ++++
 rtl/sync_edge_det.sv | 39 +++
 rtl/i2s_dac_serializer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared types and constants for the I2S DAC serializer.
//   I2S_WORD_W   : width of the sample words from the effects chain
//   I2S_CNT_W    : width of the per-slot bit counter (saturates at 63)
//   i2s_state_t  : serializer FSM state
//   payload_mask : left-justified mask selecting the payload bits of a word
// ---------------------------------------------------------------------------
package i2s_pkg;

   localparam int unsigned I2S_WORD_W = 32;
   localparam int unsigned I2S_CNT_W  = 6;
   localparam logic [I2S_CNT_W-1:0] I2S_CNT_MAX = '1;

   typedef enum logic {
      WAIT_FRAME = 1'b0,
      RUN        = 1'b1
   } i2s_state_t;

   // Keeps the top 'bits' bits of a word and clears the rest.
   function automatic logic [I2S_WORD_W-1:0] payload_mask(input int unsigned bits);
      return ~({I2S_WORD_W{1'b1}} >> bits);
   endfunction

endpackage

// File: rtl/i2s_dac_serializer_if.sv
// ---------------------------------------------------------------------------
// i2s_dac_serializer_if
// Bundles the codec pins and the sample-word bus of the serializer.
//   BCLK, LRCLK        : codec bit / word clocks (codec is bus master)
//   MUTE, DINL, DINR   : sample words from the effects chain
//   DACDAT             : serial data to the codec
//   SAMPLE_TICK, ACTIVE: frame-start pulse and alignment-acquired flag
//   FRAME_ERR          : sticky short-slot flag (only with I2S_FRAME_CHECK_EN)
// Modports: slave = serializer side, master = driving side.
// ---------------------------------------------------------------------------
interface i2s_dac_serializer_if;
   import i2s_pkg::*;

   logic                  BCLK;
   logic                  LRCLK;
   logic                  MUTE;
   logic [I2S_WORD_W-1:0] DINL;
   logic [I2S_WORD_W-1:0] DINR;
   logic                  DACDAT;
   logic                  SAMPLE_TICK;
   logic                  ACTIVE;

`ifdef I2S_FRAME_CHECK_EN
   logic                  FRAME_ERR;

   modport slave (
      input  BCLK, LRCLK, MUTE, DINL, DINR,
      output DACDAT, SAMPLE_TICK, ACTIVE, FRAME_ERR
   );

   modport master (
      output BCLK, LRCLK, MUTE, DINL, DINR,
      input  DACDAT, SAMPLE_TICK, ACTIVE, FRAME_ERR
   );
`else
   modport slave (
      input  BCLK, LRCLK, MUTE, DINL, DINR,
      output DACDAT, SAMPLE_TICK, ACTIVE
   );

   modport master (
      output BCLK, LRCLK, MUTE, DINL, DINR,
      input  DACDAT, SAMPLE_TICK, ACTIVE
   );
`endif

endinterface

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Multi-flop synchronizer followed by a rise/fall pulse detector.
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_async      : asynchronous input
//   o_rise       : one-cycle pulse when the synchronized level goes 0->1
//   o_fall       : one-cycle pulse when the synchronized level goes 1->0
// Parameter SYNC_STAGES (>= 2) sets the synchronizer depth.
// ---------------------------------------------------------------------------
module sync_edge_det #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_level;

   assign w_level = r_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= w_level;
      end
   end

   assign o_rise = w_level & ~r_prev;
   assign o_fall = ~w_level & r_prev;

endmodule

// File: rtl/i2s_dac_serializer.sv
// ---------------------------------------------------------------------------
// i2s_dac_serializer
// Serializes left/right sample words onto the codec DACDAT line in I2S
// format. BCLK/LRCLK come from the codec and are oversampled on CLK.
//   CLK, RESET : system clock, synchronous active-high reset
//   bus        : i2s_dac_serializer_if.slave
//                in : BCLK, LRCLK, MUTE, DINL, DINR
//                out: DACDAT, SAMPLE_TICK, ACTIVE (+ FRAME_ERR)
// Parameters: BITS_PER_CH (<= 32) payload bits per channel, MSB first;
//             SYNC_STAGES (>= 2) synchronizer depth for BCLK and LRCLK.
// Optional macro I2S_FRAME_CHECK_EN adds the sticky FRAME_ERR output and
// forces re-acquisition after a slot too short to carry the whole word.
// ---------------------------------------------------------------------------
module i2s_dac_serializer
   import i2s_pkg::*;
#(
   parameter int unsigned BITS_PER_CH = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   i2s_dac_serializer_if.slave   bus
);

   localparam logic [I2S_WORD_W-1:0] PAYLOAD_MASK = payload_mask(BITS_PER_CH);

   logic                  w_bfall;
   logic                  w_bclk_rise_unused;
   logic                  w_lr_rise;
   logic                  w_lr_fall;
   logic                  w_lr_edge;
   logic                  w_frame_fault;
   logic [I2S_WORD_W-1:0] w_new_word;

   i2s_state_t            r_state;
   logic [I2S_WORD_W-1:0] r_shreg;
   logic [I2S_CNT_W-1:0]  r_bitcnt;
   logic                  r_dacdat;
   logic                  r_tick;
   logic                  r_active;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
      .i_clk   (CLK),
      .i_rst   (RESET),
      .i_async (bus.BCLK),
      .o_rise  (w_bclk_rise_unused),
      .o_fall  (w_bfall)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
      .i_clk   (CLK),
      .i_rst   (RESET),
      .i_async (bus.LRCLK),
      .o_rise  (w_lr_rise),
      .o_fall  (w_lr_fall)
   );

   // Equal sync depth puts an LRCLK edge in the same cycle as its BCLK
   // fall, so an LRCLK edge alone is handled exactly like edge+bfall.
   assign w_lr_edge = w_lr_rise | w_lr_fall;

   always_comb begin
      w_new_word = '0;
      if (!bus.MUTE) begin
         w_new_word = (w_lr_fall ? bus.DINL : bus.DINR) & PAYLOAD_MASK;
      end
   end

`ifdef I2S_FRAME_CHECK_EN
   // bitcnt does not count the bfall that loaded the word, so a slot that
   // delivered every payload bit ends with bitcnt == BITS_PER_CH-1.
   localparam logic [I2S_CNT_W-1:0] SHORT_LIMIT = I2S_CNT_W'(BITS_PER_CH - 1);

   logic r_frame_err;

   assign w_frame_fault = w_lr_edge && (r_bitcnt < SHORT_LIMIT);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_frame_err <= 1'b0;
      end else if (r_state == RUN && w_frame_fault) begin
         r_frame_err <= 1'b1;
      end
   end

   assign bus.FRAME_ERR = r_frame_err;
`else
   assign w_frame_fault = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= WAIT_FRAME;
         r_shreg  <= '0;
         r_bitcnt <= '0;
         r_dacdat <= 1'b0;
         r_tick   <= 1'b0;
         r_active <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         case (r_state)
            WAIT_FRAME: begin
               r_dacdat <= 1'b0;
               // Only a right->left transition marks a frame start.
               if (w_lr_fall) begin
                  r_shreg  <= w_new_word;
                  r_bitcnt <= '0;
                  r_tick   <= 1'b1;
                  r_active <= 1'b1;
                  r_state  <= RUN;
               end
            end

            RUN: begin
               if (w_frame_fault) begin
                  r_dacdat <= 1'b0;
                  r_shreg  <= '0;
                  r_bitcnt <= '0;
                  r_active <= 1'b0;
                  r_state  <= WAIT_FRAME;
               end else if (w_lr_edge) begin
                  // Last bit of the old word goes out on the edge bfall,
                  // which yields the one-BCLK I2S data delay.
                  r_dacdat <= r_shreg[I2S_WORD_W-1];
                  r_shreg  <= w_new_word;
                  r_bitcnt <= '0;
                  r_tick   <= w_lr_fall;
               end else if (w_bfall) begin
                  r_dacdat <= r_shreg[I2S_WORD_W-1];
                  r_shreg  <= {r_shreg[I2S_WORD_W-2:0], 1'b0};
                  if (r_bitcnt != I2S_CNT_MAX) begin
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end
               end
            end

            default: begin
               r_state <= WAIT_FRAME;
            end
         endcase
      end
   end

   assign bus.DACDAT      = r_dacdat;
   assign bus.SAMPLE_TICK = r_tick;
   assign bus.ACTIVE      = r_active;

endmodule
